// File: rtl/pair_exit_if.sv
// Bundles the requester, FIFO-side and host-side signals of the pair-exit
// arbiter. The slave view is the arbiter itself. The master view is the
// surrounding logic: the pair-filter array, the FIFO and the host readout.
interface pair_exit_if #(
    parameter int N_REQ  = 14,
    parameter int DATA_W = 227,
    parameter int OUT_W  = 192,
    parameter int CNT_W  = 16
);
    // Requester side
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    // FIFO write and read ports
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_din;
    logic                    fifo_full;
    logic                    fifo_rd_en;
    logic [DATA_W-1:0]       fifo_dout;
    logic                    fifo_empty;

    // Host readout
    logic                    host_read;
    logic [OUT_W-1:0]        host_data;
    logic                    host_valid;
    logic                    host_empty;

    // Statistics
    logic [CNT_W-1:0]        drop_count;
    logic [CNT_W-1:0]        write_count;

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_dout, fifo_empty, host_read,
        output req_ready, fifo_wr_en, fifo_din, fifo_rd_en,
               host_data, host_valid, host_empty, drop_count, write_count
    );

    modport master (
        output req_valid, req_data, fifo_full, fifo_dout, fifo_empty, host_read,
        input  req_ready, fifo_wr_en, fifo_din, fifo_rd_en,
               host_data, host_valid, host_empty, drop_count, write_count
    );
endinterface

// File: rtl/pair_exit_arbiter.sv
// Pair-exit arbiter. It round-robins N_REQ requesters onto one external FIFO
// write port and drops null pair records before they are written. It also
// pops one FIFO entry for each rising edge of the host read level.
module pair_exit_arbiter #(
    parameter int N_REQ  = 14,
    parameter int DATA_W = 227,
    parameter int OUT_W  = 192,
    parameter int CNT_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    pair_exit_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Marker that makes a record null when it appears in both 97-bit fields.
    localparam logic [96:0] NULL_MARK = 97'h1 << 96;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A record is null when both flag bits are clear, or when both halves
    // carry the marker pattern.
    function automatic logic is_null(input logic [DATA_W-1:0] rec);
        logic no_flag;
        logic both_mark;
        no_flag   = ~(rec[194] | rec[195]);
        both_mark = (rec[96:0] == NULL_MARK) && (rec[193:97] == NULL_MARK);
        return no_flag | both_mark;
    endfunction

    // Statistics counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_found;
    logic              grant_ok;
    logic [DATA_W-1:0] grant_rec;
    logic              grant_null;
    logic [N_REQ-1:0]  ready;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    // Find the first valid requester, starting the search at the round-robin pointer.
    always_comb begin : grant_search
        logic [PTR_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(N_REQ)) begin
                cand = cand - (PTR_W + 1)'(N_REQ);
            end
            if (!grant_found && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign grant_rec  = bus.req_data[DATA_W*grant_idx +: DATA_W];
    assign grant_null = is_null(grant_rec);
    // Nothing is granted while the FIFO is full or the block is in reset.
    assign grant_ok   = grant_found & ~bus.fifo_full & ~reset;

    // Build the one-hot ready, the write strobe and the next-state of the pointer and counters.
    always_comb begin
        ready      = '0;
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (grant_ok) begin
            ready[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (grant_null) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.fifo_wr_en  = grant_ok & ~grant_null;
    assign bus.fifo_din    = grant_rec;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.write_count = wr_cnt_q;

    // Arbitration pointer and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Host read sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

    rd_state_t        state_q, state_d;
    logic             host_read_q;
    logic             rise;
    logic             rd_en;
    logic [OUT_W-1:0] host_data_q, host_data_d;
    logic             host_valid_q, host_valid_d;
    logic             host_empty_q, host_empty_d;
    logic             unused_dout_hi;

    // Only the payload slice of the popped record goes to the host.
    assign unused_dout_hi = ^bus.fifo_dout[DATA_W-1:OUT_W];

    assign rise = bus.host_read & ~host_read_q;

    // Next-state and output decode. A rise is honoured only in R_IDLE, so a
    // host that holds the read line high gets exactly one entry.
    always_comb begin
        state_d      = state_q;
        host_data_d  = host_data_q;
        host_valid_d = host_valid_q;
        host_empty_d = host_empty_q;
        rd_en        = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (rise) begin
                    host_valid_d = 1'b0;
                    host_data_d  = '0;
                    if (!bus.fifo_empty) begin
                        rd_en        = 1'b1;
                        host_empty_d = 1'b0;
                        state_d      = R_WAIT;
                    end else begin
                        host_empty_d = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                // FIFO dout is valid one cycle after the read strobe.
                host_data_d  = bus.fifo_dout[OUT_W-1:0];
                host_valid_d = 1'b1;
                state_d      = R_HOLD;
            end
            R_HOLD: begin
                if (!bus.host_read) begin
                    state_d = R_IDLE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    assign bus.fifo_rd_en = rd_en & ~reset;
    assign bus.host_data  = host_data_q;
    assign bus.host_valid = host_valid_q;
    assign bus.host_empty = host_empty_q;

    // Read-sequencer state and host output registers. Reset aborts any read
    // in flight; a pop already issued to the FIFO is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= R_IDLE;
            host_read_q  <= 1'b0;
            host_data_q  <= '0;
            host_valid_q <= 1'b0;
            host_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            host_read_q  <= bus.host_read;
            host_data_q  <= host_data_d;
            host_valid_q <= host_valid_d;
            host_empty_q <= host_empty_d;
        end
    end

endmodule
